control_sequencer: RTL and testbench

Moore-style control unit that sequences the single-bus CPU datapath: register file, Y/Z/HI/LO, PC, MAR/MDR, IR and ALU.
It steps through fetch (T0–T2) and per-class execute states, driving every bus-source, register-load, select-logic and memory strobe.
It sits beside the datapath top level. Its outputs drive the encoder-facing *out signals, the *in signals, and the Gra/Grb/Grc/Rin/Rout/BAout inputs of the select-and-encode logic.

---
 rtl/control_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Control sequencer for the single-bus CPU datapath.
// Moore FSM: fetch (FETCH0..FETCH2) then per-class execute steps (T3..T7).
// Control outputs depend only on the state register and, in execute
// states, on the opcode held in ir.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | after reset; all controls low, run low
//   FETCH0 | PC -> MAR, increment PC
//   FETCH1 | memory read into MDR; holds until mem_ready
//   FETCH2 | MDR -> IR; nop/halt/undefined retire here
//   T3..T7 | execute steps, meaning depends on the opcode class
//   HALT   | stopped; only clr leaves it
module control_sequencer #(
  parameter logic [4:0] ADD_OPCODE  = 5'b00011,
  parameter logic [4:0] NOP_OPCODE  = 5'b11000,
  parameter logic [4:0] HALT_OPCODE = 5'b11001
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2,
    S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_M, C_U, C_LD, C_ST, C_NOP, C_HALT
  } class_t;

  state_t      state_q, state_d;
  class_t      cls;
  logic        retire;
  logic [31:0] count_q;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode      = ir[31:27];
  assign unused_ir   = ^ir[26:0];
  assign instr_count = count_q;

  // Opcode class decode; anything unrecognised behaves as a nop.
  always_comb begin
    cls = C_NOP;
    if (opcode == HALT_OPCODE) begin
      cls = C_HALT;
    end else if (opcode == NOP_OPCODE) begin
      cls = C_NOP;
    end else begin
      case (opcode)
        5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
        5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_R;
        5'b01100, 5'b01101, 5'b01110:           cls = C_I;
        5'b01111, 5'b10000:                     cls = C_M;
        5'b10001, 5'b10010:                     cls = C_U;
        5'b00000:                               cls = C_LD;
        5'b00010:                               cls = C_ST;
        default:                                cls = C_NOP;
      endcase
    end
  end

  // Next state and retirement; the boundary exit is the only place stop matters.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: if (mem_ready) state_d = S_FETCH2;
      S_FETCH2: begin
        if (cls == C_HALT) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (cls == C_NOP) begin
          retire  = 1'b1;
          state_d = stop ? S_HALT : S_FETCH0;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: state_d = S_T4;
      S_T4: begin
        if (cls == C_R || cls == C_I || cls == C_M || cls == C_LD || cls == C_ST) begin
          state_d = S_T5;
        end else begin
          retire  = 1'b1;
          state_d = stop ? S_HALT : S_FETCH0;
        end
      end
      S_T5: begin
        if (cls == C_M || cls == C_LD || cls == C_ST) begin
          state_d = S_T6;
        end else begin
          retire  = 1'b1;
          state_d = stop ? S_HALT : S_FETCH0;
        end
      end
      S_T6: begin
        if (cls == C_ST) begin
          state_d = S_T7;
        end else if (cls == C_LD) begin
          if (mem_ready) state_d = S_T7;
        end else begin
          retire  = 1'b1;
          state_d = stop ? S_HALT : S_FETCH0;
        end
      end
      S_T7: begin
        if (cls != C_ST || mem_ready) begin
          retire  = 1'b1;
          state_d = stop ? S_HALT : S_FETCH0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and retired-instruction counter; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  // Moore output decode from state (and opcode class in execute states).
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; ZLowIn = 1'b0;
    ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; PCin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = 5'd0;
    run = (state_q != S_IDLE) && (state_q != S_HALT);
    case (state_q)
      S_FETCH0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_FETCH1: begin Read = 1'b1; MDRin = 1'b1; end
      S_FETCH2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          C_R, C_I: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_M:      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_U: begin
            Grb = 1'b1; Rout = 1'b1; alu_op = opcode; ZLowIn = 1'b1; ZHighIn = 1'b1;
          end
          C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_R: begin
            Grc = 1'b1; Rout = 1'b1; alu_op = opcode; ZLowIn = 1'b1; ZHighIn = 1'b1;
          end
          C_I: begin Cout = 1'b1; alu_op = opcode; ZLowIn = 1'b1; ZHighIn = 1'b1; end
          C_M: begin
            Grb = 1'b1; Rout = 1'b1; alu_op = opcode; ZLowIn = 1'b1; ZHighIn = 1'b1;
          end
          C_U: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin
            Cout = 1'b1; alu_op = ADD_OPCODE; ZLowIn = 1'b1; ZHighIn = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_R, C_I:   begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_M:        begin ZLowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_M:  begin ZHighout = 1'b1; HIin = 1'b1; end
          C_LD: begin Read = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. The driver pushes the hand-written
// expected control word for each cycle into a scoreboard queue; a monitor on
// the falling edge pops and compares against the DUT outputs.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, mem_ready, stop;
  logic [31:0] ir;
  logic PCout, ZLowout, ZHighout, MDRout, Cout, MARin, MDRin, IRin, Yin;
  logic ZLowIn, ZHighIn, HIin, LOin, PCin, IncPC, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [4:0]  alu_op;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .PCin(PCin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run), .instr_count(instr_count)
  );

  localparam logic [22:0] PCO  = 23'd1 << 22;
  localparam logic [22:0] ZLO  = 23'd1 << 21;
  localparam logic [22:0] ZHO  = 23'd1 << 20;
  localparam logic [22:0] MDO  = 23'd1 << 19;
  localparam logic [22:0] CO   = 23'd1 << 18;
  localparam logic [22:0] MARI = 23'd1 << 17;
  localparam logic [22:0] MDRI = 23'd1 << 16;
  localparam logic [22:0] IRI  = 23'd1 << 15;
  localparam logic [22:0] YI   = 23'd1 << 14;
  localparam logic [22:0] ZI   = (23'd1 << 13) | (23'd1 << 12);
  localparam logic [22:0] HII  = 23'd1 << 11;
  localparam logic [22:0] LOI  = 23'd1 << 10;
  localparam logic [22:0] INC  = 23'd1 << 8;
  localparam logic [22:0] RD   = 23'd1 << 7;
  localparam logic [22:0] WR   = 23'd1 << 6;
  localparam logic [22:0] GRA  = 23'd1 << 5;
  localparam logic [22:0] GRB  = 23'd1 << 4;
  localparam logic [22:0] GRC  = 23'd1 << 3;
  localparam logic [22:0] RI   = 23'd1 << 2;
  localparam logic [22:0] RO   = 23'd1 << 1;
  localparam logic [22:0] BAO  = 23'd1;

  localparam logic [22:0] F0 = PCO | MARI | INC;
  localparam logic [22:0] F1 = RD | MDRI;
  localparam logic [22:0] F2 = MDO | IRI;

  typedef struct packed {
    logic [22:0] ctl;
    logic [4:0]  alu;
    logic        run;
    logic [31:0] cnt;
  } obs_t;

  obs_t  sb[$];
  string names[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  act;

  assign act = '{ctl: {PCout, ZLowout, ZHighout, MDRout, Cout, MARin, MDRin, IRin, Yin,
                       ZLowIn, ZHighIn, HIin, LOin, PCin, IncPC, Read, Write,
                       Gra, Grb, Grc, Rin, Rout, BAout},
                 alu: alu_op, run: run, cnt: instr_count};

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t  e;
      string nm;
      e  = sb.pop_front();
      nm = names.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got ctl=%h alu=%h run=%b cnt=%0d, want ctl=%h alu=%h run=%b cnt=%0d",
                 nm, act.ctl, act.alu, act.run, act.cnt, e.ctl, e.alu, e.run, e.cnt);
      end
    end
  end

  // One cycle: expected outputs of the current state, then inputs for the coming edge.
  task automatic cyc(input string nm, input logic [22:0] c, input logic [4:0] a,
                     input logic r, input logic [31:0] n,
                     input logic mr, input logic st, input logic cl);
    sb.push_back('{ctl: c, alu: a, run: r, cnt: n});
    names.push_back(nm);
    mem_ready = mr;
    stop      = st;
    clr       = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; mem_ready = 1'b0; stop = 1'b0; ir = 32'h0;
    @(posedge clk);
    #1;

    // reset and IDLE
    cyc("rst_idle",  0, 0, 0, 0, 0, 0, 1);
    cyc("idle",      0, 0, 0, 0, 1, 1, 0);

    // add R5,R3,R1
    ir = 32'h1A98_8000;
    cyc("add_f0", F0, 0, 1, 0, 1, 0, 0);
    cyc("add_f1", F1, 0, 1, 0, 1, 0, 0);
    cyc("add_f2", F2, 0, 1, 0, 1, 1, 0);
    cyc("add_t3", GRB | RO | YI, 0, 1, 0, 1, 1, 0);
    cyc("add_t4", GRC | RO | ZI, 5'b00011, 1, 0, 1, 1, 0);
    cyc("add_t5", ZLO | GRA | RI, 0, 1, 0, 1, 0, 0);

    // ld with a 4-cycle memory wait in T6
    ir = 32'h0088_0005;
    cyc("ld_f0", F0, 0, 1, 1, 0, 0, 0);
    cyc("ld_f1", F1, 0, 1, 1, 1, 0, 0);
    cyc("ld_f2", F2, 0, 1, 1, 1, 0, 0);
    cyc("ld_t3", GRB | BAO | YI, 0, 1, 1, 1, 0, 0);
    cyc("ld_t4", CO | ZI, 5'b00011, 1, 1, 1, 0, 0);
    cyc("ld_t5", ZLO | MARI, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ld_t6_wait", F1, 0, 1, 1, 0, 1, 0);
    cyc("ld_t6_done", F1, 0, 1, 1, 1, 0, 0);
    cyc("ld_t7", MDO | GRA | RI, 0, 1, 1, 0, 0, 0);

    // mul
    ir = 32'h7800_0000;
    cyc("mul_f0", F0, 0, 1, 2, 1, 0, 0);
    cyc("mul_f1", F1, 0, 1, 2, 1, 0, 0);
    cyc("mul_f2", F2, 0, 1, 2, 1, 0, 0);
    cyc("mul_t3", GRA | RO | YI, 0, 1, 2, 1, 0, 0);
    cyc("mul_t4", GRB | RO | ZI, 5'b01111, 1, 2, 1, 0, 0);
    cyc("mul_t5", ZLO | LOI, 0, 1, 2, 1, 0, 0);
    cyc("mul_t6", ZHO | HII, 0, 1, 2, 1, 0, 0);

    // st with a 2-cycle write wait
    ir = 32'h1000_0000;
    cyc("st_f0", F0, 0, 1, 3, 1, 0, 0);
    cyc("st_f1", F1, 0, 1, 3, 1, 0, 0);
    cyc("st_f2", F2, 0, 1, 3, 1, 0, 0);
    cyc("st_t3", GRB | BAO | YI, 0, 1, 3, 1, 0, 0);
    cyc("st_t4", CO | ZI, 5'b00011, 1, 3, 1, 0, 0);
    cyc("st_t5", ZLO | MARI, 0, 1, 3, 1, 0, 0);
    cyc("st_t6", GRA | RO | MDRI, 0, 1, 3, 0, 0, 0);
    cyc("st_t7_wait", WR, 0, 1, 3, 0, 0, 0);
    cyc("st_t7_done", WR, 0, 1, 3, 1, 0, 0);

    // neg
    ir = 32'h8800_0000;
    cyc("neg_f0", F0, 0, 1, 4, 1, 0, 0);
    cyc("neg_f1", F1, 0, 1, 4, 1, 0, 0);
    cyc("neg_f2", F2, 0, 1, 4, 1, 0, 0);
    cyc("neg_t3", GRB | RO | ZI, 5'b10001, 1, 4, 1, 0, 0);
    cyc("neg_t4", ZLO | GRA | RI, 0, 1, 4, 1, 0, 0);

    // addi
    ir = 32'h6000_0000;
    cyc("addi_f0", F0, 0, 1, 5, 1, 0, 0);
    cyc("addi_f1", F1, 0, 1, 5, 1, 0, 0);
    cyc("addi_f2", F2, 0, 1, 5, 1, 0, 0);
    cyc("addi_t3", GRB | RO | YI, 0, 1, 5, 1, 0, 0);
    cyc("addi_t4", CO | ZI, 5'b01100, 1, 5, 1, 0, 0);
    cyc("addi_t5", ZLO | GRA | RI, 0, 1, 5, 1, 0, 0);

    // add with stop at its boundary, then HALT until clr
    ir = 32'h1A98_8000;
    cyc("stop_f0", F0, 0, 1, 6, 1, 0, 0);
    cyc("stop_f1", F1, 0, 1, 6, 1, 0, 0);
    cyc("stop_f2", F2, 0, 1, 6, 1, 0, 0);
    cyc("stop_t3", GRB | RO | YI, 0, 1, 6, 1, 1, 0);
    cyc("stop_t4", GRC | RO | ZI, 5'b00011, 1, 6, 1, 1, 0);
    cyc("stop_t5", ZLO | GRA | RI, 0, 1, 6, 1, 1, 0);
    cyc("halt_a", 0, 0, 0, 7, 1, 0, 0);
    cyc("halt_b", 0, 0, 0, 7, 1, 1, 0);
    cyc("halt_clr", 0, 0, 0, 7, 1, 0, 1);
    cyc("idle_after_halt", 0, 0, 0, 0, 1, 0, 0);

    // nop, then clr during a fetch wait
    ir = 32'hC000_0000;
    cyc("nop_f0", F0, 0, 1, 0, 1, 0, 0);
    cyc("nop_f1", F1, 0, 1, 0, 1, 0, 0);
    cyc("nop_f2", F2, 0, 1, 0, 1, 0, 0);
    cyc("w_f0", F0, 0, 1, 1, 0, 0, 0);
    cyc("w_f1", F1, 0, 1, 1, 0, 0, 0);
    cyc("w_f1_clr", F1, 0, 1, 1, 1, 0, 1);
    cyc("clr_idle", 0, 0, 0, 0, 1, 0, 0);

    // undefined opcode behaves as nop, then halt opcode
    ir = 32'hF800_0000;
    cyc("undef_f0", F0, 0, 1, 0, 1, 0, 0);
    cyc("undef_f1", F1, 0, 1, 0, 1, 0, 0);
    cyc("undef_f2", F2, 0, 1, 0, 1, 0, 0);
    ir = 32'hC800_0000;
    cyc("hlt_f0", F0, 0, 1, 1, 1, 0, 0);
    cyc("hlt_f1", F1, 0, 1, 1, 1, 0, 0);
    cyc("hlt_f2", F2, 0, 1, 1, 1, 0, 0);
    cyc("hlt_state_a", 0, 0, 0, 2, 1, 0, 0);
    cyc("hlt_state_b", 0, 0, 0, 2, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
